// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: the NOP filler word, instruction size
// and the fetch controller state encoding.
package rv32i_pkg;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          INSTR_BYTES = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/ifetch_fifo.sv
// DEPTH-entry FIFO holding {instruction, pc} pairs; synchronous clear wins over
// push and pop, and push while full is accepted only together with a pop.
module ifetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/ifetch_prefetch_unit.sv
// Sequential instruction prefetcher: issues in-order memory requests, buffers
// responses for decode, and flushes/kills stale traffic on a redirect.
module ifetch_prefetch_unit
  import rv32i_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            EN_PC,
  input  logic            Redirect,
  input  logic [XLEN-1:0] Redirect_Addr,
  output logic            Mem_Req,
  output logic [XLEN-1:0] Mem_Addr,
  input  logic            Mem_Gnt,
  input  logic            Mem_Rvalid,
  input  logic [31:0]     Mem_Rdata,
  output logic            Instr_Valid,
  output logic [31:0]     Instr_O,
  output logic [XLEN-1:0] PC_O,
  input  logic            Instr_Ready,
  output fetch_state_e    dbg_state
);
  localparam int              CW   = $clog2(DEPTH) + 1;
  localparam int              FW   = 32 + XLEN;
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   kill_q, kill_d;

  logic            fifo_push, fifo_pop, fifo_clr;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [FW-1:0]   fifo_head;
  logic            granted, hold;
  logic [XLEN-1:0] target;

  // Request is derived from registered counts only; since a push trades one
  // outstanding for one FIFO entry, it cannot drop while waiting for a grant.
  assign Mem_Req     = (state_q == FETCH) &&
                       ((int'(out_q) + int'(fifo_count)) < DEPTH);
  assign Mem_Addr    = addr_q;
  assign granted     = Mem_Req && Mem_Gnt;
  assign target      = Redirect_Addr & ~XLEN'(3);
  assign Instr_Valid = !fifo_empty;
  assign Instr_O     = fifo_empty ? NOP_INSTR : fifo_head[FW-1:XLEN];
  assign PC_O        = fifo_empty ? '0 : fifo_head[XLEN-1:0];
  assign dbg_state   = state_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    resp_pc_d = resp_pc_q;
    kill_d    = kill_q;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    fifo_clr  = 1'b0;
    hold      = Mem_Req && !Mem_Gnt && !Redirect;

    case (state_q)
      IDLE:    if (EN_PC) state_d = FETCH;
      FETCH:   if (!EN_PC && !hold) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    out_d = out_q + CW'(granted) - CW'(Mem_Rvalid);
    if (granted) addr_d = addr_q + STEP;

    if (Redirect && state_q == FETCH) begin
      // Everything still in flight after this cycle is stale.
      fifo_clr = 1'b1;
      kill_d   = out_d;
    end else begin
      fifo_pop = Instr_Valid && Instr_Ready;
      if (Mem_Rvalid) begin
        if (kill_q != '0) begin
          kill_d = kill_q - CW'(1);
        end else begin
          fifo_push = !fifo_full || fifo_pop;
          resp_pc_d = resp_pc_q + STEP;
        end
      end
    end

    if (Redirect) begin
      addr_d    = target;
      resp_pc_d = target;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      kill_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      kill_q    <= kill_d;
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (CLK),
    .rst   (rst),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({Mem_Rdata, resp_pc_q}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// Bench for ifetch_prefetch_unit: in-order memory responder, queue-based
// reference model compared every cycle, plus directed literal checks.
module tb_ifetch_prefetch_unit;
  import rv32i_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        EN_PC = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] Redirect_Addr = '0;
  logic        Mem_Req;
  logic [31:0] Mem_Addr;
  logic        Mem_Gnt = 1'b0;
  logic        Mem_Rvalid = 1'b0;
  logic [31:0] Mem_Rdata = '0;
  logic        Instr_Valid;
  logic [31:0] Instr_O;
  logic [31:0] PC_O;
  logic        Instr_Ready = 1'b0;
  fetch_state_e dbg_state;

  ifetch_prefetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .rst(rst), .EN_PC(EN_PC), .Redirect(Redirect),
    .Redirect_Addr(Redirect_Addr), .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr),
    .Mem_Gnt(Mem_Gnt), .Mem_Rvalid(Mem_Rvalid), .Mem_Rdata(Mem_Rdata),
    .Instr_Valid(Instr_Valid), .Instr_O(Instr_O), .PC_O(PC_O),
    .Instr_Ready(Instr_Ready), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- counters / checker ----------------
  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  // ---------------- reference model ----------------
  // exp_q holds {instr, pc} in delivery order.
  logic [63:0] exp_q[$];
  bit          m_fetch;
  logic [31:0] m_addr, m_resp_pc;
  int          m_out, m_kill;

  task automatic model_reset();
    exp_q.delete();
    m_fetch = 1'b0; m_addr = '0; m_resp_pc = '0; m_out = 0; m_kill = 0;
  endtask

  function automatic bit model_req();
    return m_fetch && (m_out + exp_q.size() < DEPTH);
  endfunction

  task automatic model_step();
    bit req, gnt, popv, was_fetch;
    logic [31:0] tgt;
    if (rst) begin model_reset(); return; end
    req = model_req();
    gnt = req && Mem_Gnt;
    tgt = {Redirect_Addr[31:2], 2'b00};
    was_fetch = m_fetch;
    popv = (exp_q.size() > 0) && Instr_Ready;
    if (!m_fetch) m_fetch = EN_PC;
    else if (!EN_PC && !(req && !Mem_Gnt && !Redirect)) m_fetch = 1'b0;
    m_out = m_out + int'(gnt) - int'(Mem_Rvalid);
    if (gnt) m_addr = m_addr + 32'd4;
    if (Redirect && was_fetch) begin
      exp_q.delete();
      m_kill = m_out;
    end else begin
      if (popv) void'(exp_q.pop_front());
      if (Mem_Rvalid) begin
        if (m_kill > 0) m_kill--;
        else begin
          exp_q.push_back({Mem_Rdata, m_resp_pc});
          m_resp_pc = m_resp_pc + 32'd4;
        end
      end
    end
    if (Redirect) begin m_addr = tgt; m_resp_pc = tgt; end
  endtask

  // ---------------- compare process ----------------
  always @(negedge CLK) begin
    if (chk_on) begin
      chk("mem_req", 64'(Mem_Req), 64'(model_req()));
      chk("mem_addr", 64'(Mem_Addr), 64'(m_addr));
      chk("instr_valid", 64'(Instr_Valid), 64'(exp_q.size() > 0));
      chk("instr_o", 64'(Instr_O), 64'(exp_q.size() > 0 ? exp_q[0][63:32] : NOP));
      chk("pc_o", 64'(PC_O), 64'(exp_q.size() > 0 ? exp_q[0][31:0] : 32'h0));
      chk("state", 64'(dbg_state), 64'(m_fetch));
    end
  end

  // ---------------- memory responder / driver ----------------
  logic [31:0] pend_q[$];
  int gnt_pct = 100, rsp_pct = 100, rdy_pct = 100;
  int grant_cnt = 0;

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(input bit redir, input logic [31:0] raddr);
    Redirect      = redir;
    Redirect_Addr = raddr;
    Mem_Gnt       = ($urandom_range(99) < gnt_pct);
    Instr_Ready   = ($urandom_range(99) < rdy_pct);
    Mem_Rvalid    = (pend_q.size() > 0) && ($urandom_range(99) < rsp_pct);
    Mem_Rdata     = Mem_Rvalid ? memf(pend_q[0]) : $urandom;
    if (Mem_Rvalid) void'(pend_q.pop_front());
    if (Mem_Req && Mem_Gnt) begin
      pend_q.push_back(Mem_Addr);
      grant_cnt++;
    end
    @(negedge CLK);
    #1 model_step();
    @(posedge CLK);
    #1;
    Redirect = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    pend_q.delete();
    EN_PC = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [31:0] got_q[$];
    @(posedge CLK); #1;
    chk_on = 1'b1;
    do_reset();
    chk("rst_req", 64'(Mem_Req), 64'(0));
    chk("rst_valid", 64'(Instr_Valid), 64'(0));
    chk("rst_instr", 64'(Instr_O), 64'(NOP));

    // Streaming fetch, 1-cycle latency.
    gnt_pct = 100; rsp_pct = 100; rdy_pct = 100;
    EN_PC = 1'b1;
    cycle(0, 0);
    chk("seq_addr0", 64'(Mem_Addr), 64'(32'h0));
    chk("seq_req", 64'(Mem_Req), 64'(1));
    cycle(0, 0);
    chk("seq_addr1", 64'(Mem_Addr), 64'(32'h4));
    cycle(0, 0);
    chk("seq_addr2", 64'(Mem_Addr), 64'(32'h8));
    chk("first_valid_at_3", 64'(Instr_Valid), 64'(1));
    chk("first_instr", 64'(Instr_O), 64'(memf(32'h0)));
    chk("first_pc", 64'(PC_O), 64'(32'h0));
    repeat (10) cycle(0, 0);

    // Decode stalled: FIFO fills with exactly DEPTH words.
    do_reset();
    EN_PC = 1'b1; rdy_pct = 0; grant_cnt = 0;
    repeat (10) cycle(0, 0);
    chk("stall_grants", 64'(grant_cnt), 64'(4));
    chk("stall_req_low", 64'(Mem_Req), 64'(0));
    chk("stall_full_valid", 64'(Instr_Valid), 64'(1));
    EN_PC = 1'b0; rdy_pct = 100;
    n = 0;
    while (got_q.size() < 6 && n < 12) begin
      if (Instr_Valid) got_q.push_back(PC_O);
      cycle(0, 0);
      n++;
    end
    chk("drain_count", 64'(got_q.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      chk("drain_pc", 64'(i < got_q.size() ? got_q[i] : 32'hFFFF_FFFF), 64'(i * 4));

    // Redirect with two outstanding and a same-cycle stale response.
    do_reset();
    EN_PC = 1'b1; rsp_pct = 0;
    cycle(0, 0);
    cycle(0, 0);
    cycle(0, 0);
    chk("pre_redir_outstanding", 64'(pend_q.size()), 64'(2));
    gnt_pct = 0; rsp_pct = 100;
    cycle(1, 32'h100);
    chk("redir_addr", 64'(Mem_Addr), 64'(32'h100));
    chk("redir_empty", 64'(Instr_Valid), 64'(0));
    gnt_pct = 100;
    n = 0;
    while (!Instr_Valid && n < 20) begin cycle(0, 0); n++; end
    chk("redir_first_pc", 64'(PC_O), 64'(32'h100));
    chk("redir_first_instr", 64'(Instr_O), 64'(memf(32'h100)));

    // Unaligned target.
    cycle(1, 32'h203);
    chk("redir_align", 64'(Mem_Addr), 64'(32'h200));
    repeat (6) cycle(0, 0);

    // Grant withheld; EN_PC drops while waiting.
    do_reset();
    EN_PC = 1'b1; gnt_pct = 0;
    cycle(0, 0);
    for (int k = 0; k < 5; k++) begin
      chk("wait_req", 64'(Mem_Req), 64'(1));
      chk("wait_addr", 64'(Mem_Addr), 64'(32'h0));
      if (k == 2) EN_PC = 1'b0;
      cycle(0, 0);
    end
    gnt_pct = 100;
    chk("wait_req_held", 64'(Mem_Req), 64'(1));
    cycle(0, 0);
    chk("wait_idle_req", 64'(Mem_Req), 64'(0));
    chk("wait_idle_state", 64'(dbg_state), 64'(IDLE));
    chk("wait_idle_addr", 64'(Mem_Addr), 64'(32'h4));
    repeat (4) cycle(0, 0);

    // Asynchronous reset with the FIFO half full.
    do_reset();
    EN_PC = 1'b1; rdy_pct = 0;
    n = 0;
    while (exp_q.size() < 2 && n < 20) begin cycle(0, 0); n++; end
    chk("half_full_reached", 64'(exp_q.size()), 64'(2));
    #1;
    rst = 1'b1;
    model_reset();
    pend_q.delete();
    #1;
    chk("arst_valid", 64'(Instr_Valid), 64'(0));
    chk("arst_instr", 64'(Instr_O), 64'(NOP));
    chk("arst_addr", 64'(Mem_Addr), 64'(32'h0));
    @(posedge CLK); #1;
    rst = 1'b0;
    rdy_pct = 100;
    cycle(0, 0);
    chk("arst_restart_req", 64'(Mem_Req), 64'(1));
    chk("arst_restart_addr", 64'(Mem_Addr), 64'(32'h0));

    // Randomized traffic.
    for (int blk = 0; blk < 40; blk++) begin
      gnt_pct = $urandom_range(100, 20);
      rsp_pct = $urandom_range(100, 20);
      rdy_pct = $urandom_range(100, 10);
      for (int c = 0; c < 50; c++) begin
        if ($urandom_range(99) < 3) EN_PC = ~EN_PC;
        if (m_fetch && $urandom_range(99) < 4)
          cycle(1, $urandom_range(32'h0000_FFFF, 0));
        else
          cycle(0, 0);
      end
    end
    EN_PC = 1'b0; gnt_pct = 100; rsp_pct = 100; rdy_pct = 100;
    repeat (12) cycle(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ifetch_prefetch_unit.md
Name: ifetch_prefetch_unit

Overview:
- Fetch front-end that sits directly upstream of the RV32I IF/ID register.
- Generates sequential instruction addresses and issues them to instruction memory over a request/grant/response interface.
- Buffers returned words in a DEPTH-entry FIFO and presents them to decode with a valid/ready handshake.
- On a pipeline redirect (branch taken or jump) it flushes the FIFO, discards stale in-flight responses and restarts at the target.

Parameters:
- XLEN, 32, address/data width.
- DEPTH, 4, FIFO entries; also the maximum number of outstanding requests. Must be a power of 2 and at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- EN_PC  input  1  fetch enable; 0 stops new requests.
- Redirect  input  1  PC change from the execute stage.
- Redirect_Addr  input  XLEN  redirect target; bits [1:0] are ignored and forced to 0.
- Mem_Req  output  1  request valid.
- Mem_Addr  output  XLEN  request address.
- Mem_Gnt  input  1  request accepted this cycle.
- Mem_Rvalid  input  1  response valid; responses return in order.
- Mem_Rdata  input  32  response instruction word.
- Instr_Valid  output  1  FIFO head is valid.
- Instr_O  output  32  head instruction; 32'h0000_0013 (NOP) when empty.
- PC_O  output  XLEN  PC of the head instruction.
- Instr_Ready  input  1  decode accepts the head (low during a stall).

Behaviour:
- Reset values:
  - Mem_Req=0, Mem_Addr=RESET_PC, Instr_Valid=0, Instr_O=32'h13, PC_O=0.
  - FIFO empty; outstanding=0; kill=0; state IDLE.
- States:
  - IDLE → FETCH when EN_PC=1.
  - FETCH → IDLE when EN_PC=0 and Mem_Req is not pending. An already-asserted Mem_Req is held until Mem_Gnt.
- Request rule:
  - Mem_Req=1 in FETCH when outstanding + fifo_count < DEPTH, using registered values. Pops in the same cycle are not credited.
  - Mem_Req and Mem_Addr stay stable until Mem_Gnt.
  - On Mem_Gnt, Mem_Addr += 4 (wraps modulo 2^XLEN) and outstanding += 1.
- Response rule:
  - On Mem_Rvalid, outstanding -= 1.
  - If kill>0, kill -= 1 and the word is dropped.
  - Otherwise push {Mem_Rdata, resp_pc} and advance resp_pc by 4.
  - Instr_Valid rises the cycle after the push; there is no bypass.
- Pop rule: when Instr_Valid and Instr_Ready, advance the head. Push and pop in the same cycle are legal, including when the FIFO is full.
- Redirect (wins over every other same-cycle event):
  - FIFO is cleared, and any same-cycle pop is ignored.
  - kill = outstanding + (Mem_Gnt ? 1 : 0) − (Mem_Rvalid ? 1 : 0). A same-cycle Rvalid is stale and dropped.
  - An ungranted pending request is withdrawn.
  - Next cycle: Mem_Addr = resp_pc = {Redirect_Addr[XLEN-1:2], 2'b00}.
  - New requests may issue while kill>0.
- Redirect in IDLE updates Mem_Addr and resp_pc only.
- Invariant: outstanding + fifo_count ≤ DEPTH, so the FIFO never overflows.
- Counter widths: $clog2(DEPTH)+1.
- rst asserted mid-operation: all state returns to reset values immediately; in-flight responses arriving after release are ignored only if they arrive while rst is high. The memory is required to share the same reset.

Decomposition:
- Shared package rv32i_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - Fetch state enum {IDLE, FETCH}.
  - INSTR_BYTES = 4.
- One sub-module: ifetch_fifo (DEPTH × (32+XLEN), synchronous clear, push/pop/full/empty/count).

Test Plan:
- Reset release, EN_PC=1, Mem_Gnt always 1, 1-cycle response latency, Instr_Ready=1 → Mem_Addr sequence 0,4,8,…; first Instr_Valid 3 cycles after reset release with Instr_O=mem[0], PC_O=0.
- Instr_Ready=0 for 10 cycles → exactly DEPTH=4 requests granted, Mem_Req drops, FIFO full. Ready=1 then delivers PCs 0,4,8,12 in order with no loss or duplication.
- Two requests outstanding, Redirect to 0x100 with Mem_Rvalid in the same cycle → all 2 stale words dropped; next Mem_Addr=0x100; first delivered PC_O=0x100.
- Redirect_Addr=0x203 → Mem_Addr=0x200.
- Mem_Gnt held low 5 cycles → Mem_Req=1 with Mem_Addr stable throughout; EN_PC dropped mid-wait → request held until grant, then IDLE with Mem_Req=0.
- rst pulsed while FIFO half full → Instr_Valid=0 and Instr_O=32'h13 in the same cycle; after release, fetch restarts at RESET_PC.
